// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - framed serial transmitter: start, WIDTH data bits, optional even parity, stop.
// Optional parity bit is compiled in when PARITY_EN is defined.
module serial_frame_tx #(
    parameter int WIDTH      = 4,
    parameter int BIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             msb_first,
    output logic             tx_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic             order_msb;
    logic [CW-1:0]    cyc;
    logic [BW-1:0]    bit_cnt;
    logic             bit_end;

    assign bit_end   = (cyc == LAST_CYC);
    assign din_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Frame bit i of the captured word, in the order latched at accept time.
    function automatic logic bit_of(input logic [BW-1:0] i);
        logic [WIDTH-1:0] lsb_view;
        logic [WIDTH-1:0] msb_view;
        lsb_view = shadow >> i;
        msb_view = shadow << i;
        return order_msb ? msb_view[WIDTH-1] : lsb_view[0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx_out    <= 1'b1;
            done      <= 1'b0;
            shadow    <= '0;
            order_msb <= 1'b0;
            cyc       <= '0;
            bit_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cyc     <= '0;
                    bit_cnt <= '0;
                    if (din_valid) begin
                        shadow    <= din;
                        order_msb <= msb_first;
                        state     <= START;
                        tx_out    <= 1'b0;
                    end else begin
                        tx_out <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cyc     <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                        tx_out  <= bit_of({BW{1'b0}});
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cyc <= '0;
                        if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_EN
                            state  <= PARITY;
                            tx_out <= ^shadow;
`else
                            state  <= STOP;
                            tx_out <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_out  <= bit_of(bit_cnt + 1'b1);
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cyc    <= '0;
                        state  <= STOP;
                        tx_out <= 1'b1;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cyc    <= '0;
                        state  <= IDLE;
                        done   <= 1'b1;
                        tx_out <= 1'b1;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - scoreboard bench for serial_frame_tx with a frame-level reference model.
module tb_serial_frame_tx;

    localparam int WIDTH      = 4;
    localparam int BIT_CYCLES = 2;
`ifdef PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F = (WIDTH + 2 + P) * BIT_CYCLES;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             msb_first;
    logic             tx_out;
    logic             busy;
    logic             done;

    int tests_run = 0;
    int tests_failed = 0;

    logic [F-1:0] exp_q[$];
    logic [F-1:0] cur;
    int           n_cur = 0;

    serial_frame_tx #(.WIDTH(WIDTH), .BIT_CYCLES(BIT_CYCLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .msb_first (msb_first),
        .tx_out    (tx_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle line level for one frame: bit k of the frame spans cycles k*BIT_CYCLES..
    function automatic logic [F-1:0] frame_of(input logic [WIDTH-1:0] d, input logic m);
        logic [F-1:0] f;
        for (int c = 0; c < F; c++) begin
            int k;
            k = c / BIT_CYCLES;
            if (k == 0)                        f[c] = 1'b0;
            else if (k <= WIDTH)               f[c] = m ? d[WIDTH - k] : d[k - 1];
            else if (P == 1 && k == WIDTH + 1) f[c] = ^d;
            else                               f[c] = 1'b1;
        end
        return f;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            n_cur = 0;
            check("rst_tx_out", tx_out, 1);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_din_ready", din_ready, 1);
        end else begin
            check("ready_vs_busy", din_ready, !busy);
            if (!busy) check("idle_tx_high", tx_out, 1);
            if (busy) begin
                if (n_cur < F) cur[n_cur] = tx_out;
                n_cur++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    logic [F-1:0] e;
                    e = exp_q.pop_front();
                    check("frame_len", n_cur, F);
                    check("frame_bits", cur, e);
                end
                n_cur = 0;
            end
        end
    end

    task automatic wait_ready();
        int w = 0;
        @(negedge clk);
        while (!din_ready && w < 4 * F) begin
            @(negedge clk);
            w++;
        end
        if (!din_ready) check("ready_timeout", din_ready, 1);
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic m);
        wait_ready();
        din       = d;
        msb_first = m;
        din_valid = 1'b1;
        exp_q.push_back(frame_of(d, m));
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = WIDTH'($urandom);
        msb_first = 1'($urandom);
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || !din_ready) && w < 8 * F) begin
            @(negedge clk);
            w++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        msb_first = 1'b0;
        #1;
        check("async_rst_tx_out", tx_out, 1);
        check("async_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_done", done, 0);

        send(4'b1101, 1'b0);
        drain();
        send(4'b1101, 1'b1);
        drain();
        send(4'b1001, 1'b0);
        drain();

        // Held din_valid with din scrambled mid-frame; second word taken in the done cycle.
        begin
            int c = 0;
            wait_ready();
            din       = 4'b0110;
            msb_first = 1'b0;
            din_valid = 1'b1;
            exp_q.push_back(frame_of(4'b0110, 1'b0));
            @(posedge clk);
            while (c < 4 * F) begin
                @(negedge clk);
                c++;
                if (din_ready) break;
                din       = WIDTH'($urandom);
                msb_first = 1'($urandom);
            end
            check("b2b_spacing", c, F + 1);
            exp_q.push_back(frame_of(din, msb_first));
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            drain();
        end

        // Abort in DATA with zero data bits so the line is low when reset hits.
        wait_ready();
        din       = '0;
        msb_first = 1'b0;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        repeat (2 * BIT_CYCLES + 1) @(posedge clk);
        #2;
        check("pre_abort_tx_low", tx_out, 0);
        rst = 1'b1;
        #1;
        check("abort_tx_out", tx_out, 1);
        check("abort_busy", busy, 0);
        check("abort_din_ready", din_ready, 1);
        check("abort_done", done, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (F + 2) @(negedge clk);
        send(4'b1011, 1'b1);
        drain();

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(WIDTH'($urandom), 1'($urandom));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
